kf_param_loader: RTL and testbench

Upstream feeder for `kf_top`. It buffers a stream of sign-magnitude Q9.14 words from a valid/ready source and, on command, issues the `kf_top` START pulse. It then delivers the initial parameter block on `DATA_IN` at one word per cycle, which the core requires because it cannot stall. During continuous operation it supplies a fresh measurement each time the core reaches its loop point.

---
 rtl/kf_param_loader.sv | 162 ++++++++++++++++
 tb/tb_kf_param_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_param_loader.sv
// -----------------------------------------------------------------------------
// kf_param_loader
//   Buffers sign-magnitude Q9.14 words from a valid/ready source and feeds
//   kf_top. On go, it waits until a full parameter block is buffered. It then
//   pulses kf_start and streams the block on kf_data at one word per cycle,
//   because the core cannot stall. After the block it enters RUN and hands
//   over one buffered word per meas_req. Words pass through bit-exact.
//
// Ports
//   clk, rst      : single rising-edge clock, synchronous active-high reset
//   s_valid/ready : upstream handshake, s_data is the word
//   go            : start the initial load (only looked at in IDLE)
//   halt          : synchronous abort, flushes FIFO and returns to IDLE
//   meas_req      : core loop point, one new measurement wanted
//   kf_start      : one-cycle START pulse, aligned with word 0 on kf_data
//   kf_data       : registered data word to kf_top.DATA_IN
//   busy          : state is not IDLE
//   underrun      : sticky, meas_req seen with an empty FIFO
//   o_dbg_state   : current FSM state (0 IDLE, 1 ARM, 2 BURST, 3 RUN)
//
// Handshake: a word transfers in every cycle where s_valid && s_ready are
// both high at the rising edge. s_ready depends only on the FIFO occupancy,
// never on s_valid. The source may raise s_valid at any time and must hold
// s_data until the transfer happens.
// -----------------------------------------------------------------------------
module kf_param_loader #(
   parameter int W      = 24,
   parameter int NPARAM = 21,
   parameter int DEPTH  = 32,
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   input  logic [W-1:0] s_data,
   output logic         s_ready,
   input  logic         go,
   input  logic         halt,
   input  logic         meas_req,
   output logic         kf_start,
   output logic [W-1:0] kf_data,
   output logic         busy,
   output logic         underrun,
   output logic [1:0]   o_dbg_state
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_BURST = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   state_t         r_state;
   logic [W-1:0]   r_mem [DEPTH];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [CW-1:0]  r_count;
   logic [CW-1:0]  r_burst_cnt;
   logic           r_kf_start;
   logic [W-1:0]   r_kf_data;
   logic           r_underrun;

   logic           w_push;
   logic           w_pop;
   logic [W-1:0]   w_head;

   assign s_ready = (r_count < CW'(DEPTH));
   assign w_push  = s_valid && s_ready;
   assign w_head  = r_mem[r_rptr];

   // Pop decision: in ARM, only when the whole block is present. In BURST,
   // while words of the block remain. In RUN, on a measurement request when
   // a word is available.
   always_comb begin
      w_pop = 1'b0;
      case (r_state)
         ST_ARM:   w_pop = (r_count >= CW'(NPARAM));
         ST_BURST: w_pop = (r_burst_cnt != '0) && (r_count != '0);
         ST_RUN:   w_pop = meas_req && (r_count != '0);
         default:  w_pop = 1'b0;
      endcase
   end

   // Storage has no reset. The pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= s_data;
      end
   end

   // Occupancy and pointers. halt flushes the FIFO the same way reset does.
   always_ff @(posedge clk) begin
      if (rst || halt) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst || halt) begin
         r_state     <= ST_IDLE;
         r_kf_start  <= 1'b0;
         r_kf_data   <= '0;
         r_underrun  <= 1'b0;
         r_burst_cnt <= '0;
      end else begin
         r_kf_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_kf_data <= '0;
               if (go) r_state <= ST_ARM;
            end
            ST_ARM: begin
               if (w_pop) begin
                  r_kf_data   <= w_head;
                  r_kf_start  <= 1'b1;
                  r_burst_cnt <= CW'(NPARAM - 1);
                  r_state     <= (NPARAM == 1) ? ST_RUN : ST_BURST;
               end
            end
            ST_BURST: begin
               // r_burst_cnt counts the words of the block still to drive.
               if (r_burst_cnt != '0) begin
                  r_kf_data   <= w_head;
                  r_burst_cnt <= r_burst_cnt - 1'b1;
               end else begin
                  r_kf_data <= '0;
                  r_state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_pop) begin
                  r_kf_data <= w_head;
               end else if (meas_req) begin
                  r_underrun <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign kf_start    = r_kf_start;
   assign kf_data     = r_kf_data;
   assign underrun    = r_underrun;
   assign busy        = (r_state != ST_IDLE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_kf_param_loader.sv
// Two instances share the stimulus. dut_a has NPARAM=6 and dut_b has
// NPARAM=21. sel picks which instance receives the handshake and control
// inputs and which outputs are observed. Outputs are sampled on the falling
// edge, and inputs are changed at that same point for the next rising edge.
module tb_kf_param_loader;

   localparam int W     = 24;
   localparam int DEPTH = 32;
   localparam int NP_A  = 6;
   localparam int NP_B  = 21;

   logic         clk = 1'b0;
   logic         rst, s_valid, go, halt, meas_req, sel;
   logic [W-1:0] s_data;

   logic         a_s_ready, a_kf_start, a_busy, a_underrun;
   logic [W-1:0] a_kf_data;
   logic [1:0]   a_dbg;
   logic         b_s_ready, b_kf_start, b_busy, b_underrun;
   logic [W-1:0] b_kf_data;
   logic [1:0]   b_dbg;

   logic         s_ready, kf_start, busy, underrun;
   logic [W-1:0] kf_data;

   logic [W-1:0] exp_q[$];
   int           np;
   int           n_cmp = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   kf_param_loader #(.W(W), .NPARAM(NP_A), .DEPTH(DEPTH)) dut_a (
      .clk(clk), .rst(rst),
      .s_valid(s_valid && !sel), .s_data(s_data), .s_ready(a_s_ready),
      .go(go && !sel), .halt(halt && !sel), .meas_req(meas_req && !sel),
      .kf_start(a_kf_start), .kf_data(a_kf_data), .busy(a_busy),
      .underrun(a_underrun), .o_dbg_state(a_dbg)
   );

   kf_param_loader #(.W(W), .NPARAM(NP_B), .DEPTH(DEPTH)) dut_b (
      .clk(clk), .rst(rst),
      .s_valid(s_valid && sel), .s_data(s_data), .s_ready(b_s_ready),
      .go(go && sel), .halt(halt && sel), .meas_req(meas_req && sel),
      .kf_start(b_kf_start), .kf_data(b_kf_data), .busy(b_busy),
      .underrun(b_underrun), .o_dbg_state(b_dbg)
   );

   assign s_ready  = sel ? b_s_ready  : a_s_ready;
   assign kf_start = sel ? b_kf_start : a_kf_start;
   assign kf_data  = sel ? b_kf_data  : a_kf_data;
   assign busy     = sel ? b_busy     : a_busy;
   assign underrun = sel ? b_underrun : a_underrun;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      s_valid = 1'b0; go = 1'b0; halt = 1'b0; meas_req = 1'b0; s_data = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // The model accepts a word only when it has room for it.
   task automatic push(input logic [W-1:0] d);
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      s_valid = 1'b1;
      s_data  = d;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   // Called in cycle S: checks np words back to back, then zero.
   task automatic check_burst(input string tag);
      logic [W-1:0] exp;
      logic         exp_st;
      for (int i = 0; i < np; i++) begin
         exp    = exp_q.pop_front();
         exp_st = (i == 0);
         n_cmp++;
         if (kf_start !== exp_st) begin
            n_err++;
            $display("FAIL %s start@S+%0d: got %b want %b", tag, i, kf_start, exp_st);
         end
         n_cmp++;
         if (kf_data !== exp) begin
            n_err++;
            $display("FAIL %s word@S+%0d: got %h want %h", tag, i, kf_data, exp);
         end
         tick();
      end
      n_cmp++;
      if (kf_data !== '0 || kf_start !== 1'b0) begin
         n_err++;
         $display("FAIL %s tail: data %h start %b want 0 0", tag, kf_data, kf_start);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      sel = 1'b0; np = NP_A;
      do_reset();
      n_cmp++;
      if ({kf_start, busy, underrun, s_ready} !== 4'b0001 || kf_data !== '0) begin
         n_err++;
         $display("FAIL reset_a: start %b busy %b underrun %b ready %b data %h want 0 0 0 1 0",
                  kf_start, busy, underrun, s_ready, kf_data);
      end
      sel = 1'b1;
      n_cmp++;
      if ({kf_start, busy, underrun, s_ready} !== 4'b0001 || kf_data !== '0) begin
         n_err++;
         $display("FAIL reset_b: start %b busy %b underrun %b ready %b data %h want 0 0 0 1 0",
                  kf_start, busy, underrun, s_ready, kf_data);
      end
      sel = 1'b0;
   endtask

   task automatic test_load_1d();
      logic [W-1:0] vec [6];
      vec = '{24'h004000, 24'h0000A3, 24'h000666, 24'h000000, 24'h004000, 24'h00A000};
      sel = 1'b0; np = NP_A;
      do_reset();
      foreach (vec[i]) push(vec[i]);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL load1d busy@g: got %b want 0", busy);
      end
      pulse_go();
      n_cmp++;
      if (busy !== 1'b1 || kf_start !== 1'b0) begin
         n_err++; $display("FAIL load1d g+1: busy %b start %b want 1 0", busy, kf_start);
      end
      tick();
      check_burst("load1d");
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL load1d busy@run: got %b want 1", busy);
      end
   endtask

   task automatic test_run_meas();
      logic [W-1:0] exp;
      int           bad = 0;
      logic [W-1:0] bad_val = '0;
      push(24'h002CCC);
      meas_req = 1'b1;
      tick();
      meas_req = 1'b0;
      exp = exp_q.pop_front();
      n_cmp++;
      if (kf_data !== exp) begin
         n_err++; $display("FAIL meas m+1: got %h want %h", kf_data, exp);
      end
      for (int c = 0; c < 200; c++) begin
         tick();
         if (kf_data !== exp) begin bad++; bad_val = kf_data; end
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++; $display("FAIL meas hold: %0d cycles changed, last %h want %h", bad, bad_val, exp);
      end
      n_cmp++;
      if (underrun !== 1'b0) begin
         n_err++; $display("FAIL meas underrun: got %b want 0", underrun);
      end
   endtask

   task automatic test_underrun();
      logic [W-1:0] exp;
      logic [W-1:0] prev;
      int           n;
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) push(W'($urandom));
      meas_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         if (i == n - 1) meas_req = 1'b0;
         exp = exp_q.pop_front();
         n_cmp++;
         if (kf_data !== exp) begin
            n_err++; $display("FAIL b2b meas %0d: got %h want %h", i, kf_data, exp);
         end
      end
      prev = exp;
      meas_req = 1'b1;
      tick();
      meas_req = 1'b0;
      n_cmp++;
      if (kf_data !== prev || underrun !== 1'b1) begin
         n_err++; $display("FAIL underrun raise: data %h underrun %b want %h 1", kf_data, underrun, prev);
      end
      repeat (5) tick();
      n_cmp++;
      if (underrun !== 1'b1 || kf_data !== prev) begin
         n_err++; $display("FAIL underrun sticky: data %h underrun %b want %h 1", kf_data, underrun, prev);
      end
      push(W'($urandom));
      meas_req = 1'b1;
      tick();
      meas_req = 1'b0;
      exp = exp_q.pop_front();
      n_cmp++;
      if (kf_data !== exp || underrun !== 1'b1) begin
         n_err++; $display("FAIL underrun recover: data %h underrun %b want %h 1", kf_data, underrun, exp);
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      exp_q.delete();
      n_cmp++;
      if (underrun !== 1'b0 || busy !== 1'b0 || kf_data !== '0 || s_ready !== 1'b1) begin
         n_err++;
         $display("FAIL halt in run: underrun %b busy %b data %h ready %b want 0 0 0 1",
                  underrun, busy, kf_data, s_ready);
      end
   endtask

   task automatic test_full();
      logic [W-1:0] d;
      logic         exp_rdy;
      int           n_acc = 0;
      sel = 1'b0; np = NP_A;
      do_reset();
      d = W'($urandom);
      s_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         s_data  = d;
         exp_rdy = (exp_q.size() < DEPTH);
         n_cmp++;
         if (s_ready !== exp_rdy) begin
            n_err++; $display("FAIL full ready c%0d: got %b want %b", c, s_ready, exp_rdy);
         end
         if (s_ready === 1'b1) n_acc++;
         if (exp_rdy) begin
            exp_q.push_back(d);
            d = d + 1'b1;
         end
         tick();
      end
      s_valid = 1'b0;
      n_cmp++;
      if (n_acc != DEPTH) begin
         n_err++; $display("FAIL full accepted: got %0d want %0d", n_acc, DEPTH);
      end
      pulse_go();
      n_cmp++;
      if (s_ready !== 1'b0) begin
         n_err++; $display("FAIL full ready@arm: got %b want 0", s_ready);
      end
      tick();
      n_cmp++;
      if (s_ready !== 1'b1) begin
         n_err++; $display("FAIL full ready after pop: got %b want 1", s_ready);
      end
      check_burst("full_replay");
   endtask

   task automatic test_abort(input bit use_rst);
      logic [W-1:0] exp;
      int           extra;
      sel = 1'b0; np = NP_A;
      do_reset();
      extra = $urandom_range(0, 3);
      for (int i = 0; i < NP_A + extra; i++) push(W'($urandom));
      pulse_go();
      tick();
      for (int i = 0; i < 4; i++) begin
         exp = exp_q.pop_front();
         n_cmp++;
         if (kf_data !== exp) begin
            n_err++; $display("FAIL abort%0d word%0d: got %h want %h", use_rst, i, kf_data, exp);
         end
         if (i < 3) tick();
      end
      if (use_rst) rst = 1'b1; else halt = 1'b1;
      tick();
      rst = 1'b0; halt = 1'b0;
      exp_q.delete();
      n_cmp++;
      if (kf_data !== '0 || kf_start !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0 || s_ready !== 1'b1) begin
         n_err++;
         $display("FAIL abort%0d state: data %h start %b busy %b underrun %b ready %b want 0 0 0 0 1",
                  use_rst, kf_data, kf_start, busy, underrun, s_ready);
      end
      pulse_go();
      for (int c = 0; c < 8; c++) begin
         n_cmp++;
         if (kf_start !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL abort%0d wait c%0d: start %b busy %b want 0 1", use_rst, c, kf_start, busy);
         end
         tick();
      end
      for (int i = 0; i < NP_A; i++) push(W'($urandom));
      n_cmp++;
      if (kf_start !== 1'b0) begin
         n_err++; $display("FAIL abort%0d early start: got %b want 0", use_rst, kf_start);
      end
      tick();
      check_burst(use_rst ? "abort_rst" : "abort_halt");
   endtask

   task automatic test_go_before_fill();
      sel = 1'b1; np = NP_B;
      do_reset();
      for (int i = 0; i < 5; i++) push(W'($urandom));
      pulse_go();
      for (int k = 5; k < NP_B; k++) begin
         for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (kf_start !== 1'b0) begin
               n_err++; $display("FAIL fill early start k%0d c%0d: got %b want 0", k, c, kf_start);
            end
            if (c < 2) tick(); else push(W'($urandom));
         end
      end
      n_cmp++;
      if (kf_start !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL fill p+1: start %b busy %b want 0 1", kf_start, busy);
      end
      tick();
      check_burst("fill21");
      sel = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0; np = NP_A;
      rst = 1'b1; s_valid = 1'b0; go = 1'b0; halt = 1'b0; meas_req = 1'b0; s_data = '0;
      tick();
      test_reset();
      test_load_1d();
      test_run_meas();
      test_underrun();
      test_full();
      test_abort(1'b0);
      test_abort(1'b1);
      test_go_before_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
